// File: rtl/board_gpi_conditioner.sv
// Board GPI conditioner: per-channel synchroniser, cycle-count debouncer,
// registered rise/fall pulses and sticky write-1-to-clear interrupt pending bits.
module board_gpi_conditioner #(
    parameter int unsigned         GpiWidth       = 8,
    parameter int unsigned         SyncStages     = 2,
    parameter int unsigned         DebounceCycles = 250000,
    parameter logic [GpiWidth-1:0] ResetValue     = '0
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_ni,
    input  logic [GpiWidth-1:0] gp_raw_i,
    output logic [GpiWidth-1:0] gp_o,
    output logic [GpiWidth-1:0] rise_o,
    output logic [GpiWidth-1:0] fall_o,
    input  logic [GpiWidth-1:0] irq_rise_en_i,
    input  logic [GpiWidth-1:0] irq_fall_en_i,
    input  logic [GpiWidth-1:0] irq_clear_i,
    output logic [GpiWidth-1:0] irq_pending_o,
    output logic                irq_o
);

    localparam int unsigned         CntWidth = $clog2(DebounceCycles + 1);
    localparam logic [CntWidth-1:0] CntMax   = CntWidth'(DebounceCycles - 1);

    logic [SyncStages-1:0][GpiWidth-1:0] sync_q;
    logic [GpiWidth-1:0]                 sync_last;

    logic [GpiWidth-1:0][CntWidth-1:0]   cnt_q, cnt_d;
    logic [GpiWidth-1:0]                 gp_q, gp_d;
    logic [GpiWidth-1:0]                 rise_q, rise_d;
    logic [GpiWidth-1:0]                 fall_q, fall_d;
    logic [GpiWidth-1:0]                 pend_q, pend_d;

    // Plain flop chain; stage 0 is the metastability-catching stage.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q <= {SyncStages{ResetValue}};
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], gp_raw_i};
        end
    end

    assign sync_last = sync_q[SyncStages-1];

    // Debounce: a level is accepted once it has disagreed with gp for
    // DebounceCycles consecutive cycles; any agreement restarts the count.
    always_comb begin
        cnt_d  = cnt_q;
        gp_d   = gp_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(GpiWidth); i++) begin
            if (sync_last[i] == gp_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                cnt_d[i]  = '0;
                gp_d[i]   = sync_last[i];
                rise_d[i] = sync_last[i];
                fall_d[i] = ~sync_last[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end
        end
    end

    // Set has priority over a coincident clear.
    always_comb begin
        pend_d = (pend_q & ~irq_clear_i)
               | (rise_q & irq_rise_en_i)
               | (fall_q & irq_fall_en_i);
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            cnt_q  <= '0;
            gp_q   <= ResetValue;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            gp_q   <= gp_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
        end
    end

    assign gp_o          = gp_q;
    assign rise_o        = rise_q;
    assign fall_o        = fall_q;
    assign irq_pending_o = pend_q;
    assign irq_o         = |pend_q;

endmodule
